spi_command_sequencer: RTL and testbench
========================================

Name: spi_command_sequencer

Overview:
- Consumes the byte stream produced by the SPI byte reader and sequences the multi-byte SPI commands.
- SAVE_SPRITE payloads become sprite-RAM write strobes; DRAW_SPRITE payloads become queued draw requests for the renderer.
- Sits between the SPI front end and the sprite memory / draw engine. Owns command framing, payload counting, abort on chip-select and draw-queue back-pressure.

Parameters:
- CMD_SAVE_SPRITE, 8'h01, opcode: 1 sprite-id byte + SPRITE_BYTES pixel bytes follow
- CMD_DRAW_SPRITE, 8'h02, opcode: 6 argument bytes follow
- SPRITE_BYTES, 512, pixel bytes per sprite; sprite_addr width = clog2(SPRITE_BYTES)
- FIFO_DEPTH, 4, draw-request queue entries (power of 2, >=2)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cs  in  1  SPI chip select, high = deselected; high aborts the current frame
- byte_valid  in  1  one-cycle pulse: byte_data holds a new received byte
- byte_data  in  8  received byte
- sprite_we  out  1  one-cycle sprite-RAM write strobe
- sprite_id  out  8  sprite being written
- sprite_addr  out  9  pixel index within the sprite
- sprite_wdata  out  8  pixel value
- draw_valid  out  1  head of draw queue valid
- draw_ready  in  1  renderer accepts head entry when draw_valid && draw_ready
- draw_id  out  8  sprite id of head entry
- draw_x  out  16  x position of head entry
- draw_y  out  16  y position of head entry
- draw_flags  out  8  flags byte of head entry
- busy  out  1  high while state != IDLE
- overflow  out  1  one-cycle pulse: completed draw command dropped, queue full
- bad_cmd  out  1  one-cycle pulse: unknown opcode received in IDLE

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, counters=0, queue emptied. All outputs 0: sprite_we, sprite_id, sprite_addr, sprite_wdata, draw_valid, draw_id, draw_x, draw_y, draw_flags, busy, overflow, bad_cmd. Reset has priority over all other inputs.
- States:
  - IDLE: on byte_valid, byte==CMD_SAVE_SPRITE -> SAVE_ID; byte==CMD_DRAW_SPRITE -> DRAW_ARGS with arg_cnt=0. Any other byte: pulse bad_cmd next cycle, stay in IDLE.
  - SAVE_ID: on byte_valid, latch sprite_id, clear pix_cnt, go to SAVE_DATA.
  - SAVE_DATA: on each byte_valid, registered one cycle later: sprite_we=1, sprite_addr=pix_cnt, sprite_wdata=byte. Then pix_cnt++. The byte with pix_cnt==SPRITE_BYTES-1 returns the FSM to IDLE. No wrap into the next sprite.
  - DRAW_ARGS: bytes in order are id, x_hi, x_lo, y_hi, y_lo, flags, shifted into an argument register. Multi-byte fields are big-endian. On the 6th byte, push {id,x,y,flags} to the queue and go to IDLE.
- sprite_we is asserted for exactly one cycle per pixel byte, 1-cycle latency after byte_valid. sprite_id is held stable through the whole payload.
- Draw queue is a FIFO of FIFO_DEPTH entries with registered outputs. The head is visible on draw_* with draw_valid=1 the cycle after the push when the queue was empty.
- Pop happens on draw_valid && draw_ready. draw_* must remain stable while draw_valid && !draw_ready.
- Push when full with no pop in the same cycle: entry discarded, overflow pulses 1 cycle, FSM still returns to IDLE.
- Push when full with a pop in the same cycle: push accepted, no overflow.
- Push and pop in the same cycle at 1 entry: the new entry becomes head next cycle, draw_valid stays 1.
- cs high in any non-IDLE state: FSM goes to IDLE next cycle.
  - Partial draw arguments are discarded; no push.
  - Sprite bytes already written remain written.
  - No sprite_we is generated for a byte_valid arriving in the same cycle as cs high.
  - Queue contents and the draw handshake are unaffected by cs.
- byte_valid while cs is high is ignored in every state.
- busy = (state != IDLE), registered.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with random inputs -> all outputs 0, busy=0, draw_valid=0.
- SAVE_SPRITE: send 01, 07, then 512 bytes of value (i & 8'hFF) -> 512 sprite_we pulses, sprite_id=7, addr 0..511 with matching data. busy falls after the last byte. A following byte 02 is decoded as a command.
- DRAW_SPRITE with draw_ready=1: send 02, 03, 01, 2C, 00, C8, 05 -> one entry: draw_id=3, draw_x=300, draw_y=200, draw_flags=5. Popped in 1 cycle, queue empty afterwards.
- Back-pressure: draw_ready=0, send 5 DRAW commands with ids 1..5 -> 4 entries queued, overflow pulses once, on id 5. Raise draw_ready -> ids 1,2,3,4 popped in order with fields stable while stalled.
- Abort: send 01, 09, 100 pixel bytes, raise cs -> exactly 100 writes, busy=0. Then send 02 plus 3 argument bytes and raise cs -> no push. Lower cs, send a full DRAW -> one entry queued.
- Unknown opcode: send FF -> bad_cmd pulses once, busy stays 0. Next byte 02 starts a DRAW normally.

Source files
------------

// File: rtl/spi_command_sequencer_if.sv
// ----------------------------------------------------------------------------
// spi_command_sequencer_if
//   Bundles the byte stream from the SPI front end, the sprite-RAM write port
//   and the draw-request handshake of spi_command_sequencer.
//
//   slave  : the sequencer (consumes bytes, produces writes and draw requests)
//   master : the surrounding system (SPI reader, sprite RAM, renderer)
//
//   cs, byte_valid, byte_data     : SPI byte stream (cs high = deselected)
//   sprite_we/id/addr/wdata       : one-cycle sprite-RAM write strobe + data
//   draw_valid/ready, draw_*      : head of the draw-request queue
//   busy, overflow, bad_cmd       : status and one-cycle event pulses
// ----------------------------------------------------------------------------
interface spi_command_sequencer_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              cs;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              sprite_we;
  logic [7:0]        sprite_id;
  logic [ADDR_W-1:0] sprite_addr;
  logic [7:0]        sprite_wdata;
  logic              draw_valid;
  logic              draw_ready;
  logic [7:0]        draw_id;
  logic [15:0]       draw_x;
  logic [15:0]       draw_y;
  logic [7:0]        draw_flags;
  logic              busy;
  logic              overflow;
  logic              bad_cmd;

  modport slave (
    input  cs, byte_valid, byte_data, draw_ready,
    output sprite_we, sprite_id, sprite_addr, sprite_wdata,
    output draw_valid, draw_id, draw_x, draw_y, draw_flags,
    output busy, overflow, bad_cmd
  );

  modport master (
    output cs, byte_valid, byte_data, draw_ready,
    input  sprite_we, sprite_id, sprite_addr, sprite_wdata,
    input  draw_valid, draw_id, draw_x, draw_y, draw_flags,
    input  busy, overflow, bad_cmd
  );
endinterface

// File: rtl/spi_command_sequencer.sv
// ----------------------------------------------------------------------------
// spi_command_sequencer
//   Frames the SPI byte stream into commands. SAVE_SPRITE payloads turn into
//   sprite-RAM write strobes (one per pixel byte, one cycle after the byte);
//   DRAW_SPRITE arguments are assembled into a request and pushed into a small
//   draw queue consumed by the renderer with a valid/ready handshake.
//   Raising cs aborts any frame in progress; the draw queue is unaffected.
//
// Ports:
//   clock : system clock
//   reset : synchronous, active-low reset (priority over everything)
//   bus   : spi_command_sequencer_if.slave (byte stream in, sprite writes
//           and draw requests out, busy/overflow/bad_cmd status)
// ----------------------------------------------------------------------------
module spi_command_sequencer #(
  parameter logic [7:0]  CMD_SAVE_SPRITE = 8'h01,
  parameter logic [7:0]  CMD_DRAW_SPRITE = 8'h02,
  parameter int unsigned SPRITE_BYTES    = 512,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic                    clock,
  input logic                    reset,
  spi_command_sequencer_if.slave bus
);

  localparam int unsigned       ADDR_W   = $clog2(SPRITE_BYTES);
  localparam int unsigned       PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(SPRITE_BYTES - 1);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SAVE_ID   = 2'd1;
  localparam logic [1:0] ST_SAVE_DATA = 2'd2;
  localparam logic [1:0] ST_DRAW_ARGS = 2'd3;

  // Layout matches the argument byte order, so an entry is simply the five
  // shifted argument bytes followed by the flags byte.
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } draw_entry_t;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [2:0]        arg_cnt_q, arg_cnt_d;
  logic [39:0]       arg_q, arg_d;
  logic              sprite_we_q, sprite_we_d;
  logic [7:0]        sprite_id_q, sprite_id_d;
  logic [ADDR_W-1:0] sprite_addr_q, sprite_addr_d;
  logic [7:0]        sprite_wdata_q, sprite_wdata_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic              overflow_q, overflow_d;
  logic              busy_q;

  draw_entry_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              take, push, pop, full, push_ok;
  draw_entry_t       push_entry, head;

  // A byte only counts while the chip is selected.
  assign take = bus.byte_valid && !bus.cs;

  // --------------------------------------------------------------------------
  // Command framing FSM
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    arg_cnt_d      = arg_cnt_q;
    arg_d          = arg_q;
    sprite_id_d    = sprite_id_q;
    sprite_addr_d  = sprite_addr_q;
    sprite_wdata_d = sprite_wdata_q;
    sprite_we_d    = 1'b0;
    bad_cmd_d      = 1'b0;
    push           = 1'b0;

    if (bus.cs) begin
      // Deselect abandons the frame; partial draw arguments are simply dropped.
      state_d = ST_IDLE;
    end else if (take) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.byte_data == CMD_SAVE_SPRITE) begin
            state_d = ST_SAVE_ID;
          end else if (bus.byte_data == CMD_DRAW_SPRITE) begin
            state_d   = ST_DRAW_ARGS;
            arg_cnt_d = '0;
          end else begin
            bad_cmd_d = 1'b1;
          end
        end
        ST_SAVE_ID: begin
          sprite_id_d = bus.byte_data;
          pix_cnt_d   = '0;
          state_d     = ST_SAVE_DATA;
        end
        ST_SAVE_DATA: begin
          sprite_we_d    = 1'b1;
          sprite_addr_d  = pix_cnt_q;
          sprite_wdata_d = bus.byte_data;
          pix_cnt_d      = pix_cnt_q + 1'b1;
          if (pix_cnt_q == LAST_PIX) state_d = ST_IDLE;
        end
        ST_DRAW_ARGS: begin
          if (arg_cnt_q == 3'd5) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            arg_d     = {arg_q[31:0], bus.byte_data};
            arg_cnt_d = arg_cnt_q + 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Draw queue
  // --------------------------------------------------------------------------
  assign push_entry = {arg_q, bus.byte_data};
  assign pop        = (cnt_q != '0) && bus.draw_ready;
  assign full       = (cnt_q == FULL_CNT);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push && (!full || pop);

  always_comb begin
    cnt_d      = cnt_q;
    overflow_d = push && !push_ok;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q        <= ST_IDLE;
      pix_cnt_q      <= '0;
      arg_cnt_q      <= '0;
      arg_q          <= '0;
      sprite_we_q    <= 1'b0;
      sprite_id_q    <= '0;
      sprite_addr_q  <= '0;
      sprite_wdata_q <= '0;
      bad_cmd_q      <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      cnt_q          <= '0;
      // NOTE: the queue storage is reset because the head entry drives draw_*
      // directly and those outputs must read zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      arg_cnt_q      <= arg_cnt_d;
      arg_q          <= arg_d;
      sprite_we_q    <= sprite_we_d;
      sprite_id_q    <= sprite_id_d;
      sprite_addr_q  <= sprite_addr_d;
      sprite_wdata_q <= sprite_wdata_d;
      bad_cmd_q      <= bad_cmd_d;
      overflow_q     <= overflow_d;
      busy_q         <= (state_d != ST_IDLE);
      cnt_q          <= cnt_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign head             = mem_q[rd_ptr_q];
  assign bus.sprite_we    = sprite_we_q;
  assign bus.sprite_id    = sprite_id_q;
  assign bus.sprite_addr  = sprite_addr_q;
  assign bus.sprite_wdata = sprite_wdata_q;
  assign bus.draw_valid   = (cnt_q != '0);
  assign bus.draw_id      = head.id;
  assign bus.draw_x       = head.x;
  assign bus.draw_y       = head.y;
  assign bus.draw_flags   = head.flags;
  assign bus.busy         = busy_q;
  assign bus.overflow     = overflow_q;
  assign bus.bad_cmd      = bad_cmd_q;

endmodule

// File: tb/tb_spi_command_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_command_sequencer
//   Self-checking bench for spi_command_sequencer: table-driven draw decode and
//   opcode vectors, hand-written multi-cycle sequences (save, back-pressure,
//   abort) and a randomized command stream checked against a queue-level
//   reference model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_command_sequencer;

  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } entry_t;

  typedef struct {
    logic [55:0] bytes;
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } draw_vec_t;

  typedef struct {
    logic [7:0] op;
    logic       exp_bad;
  } op_vec_t;

  logic clock = 1'b0;
  logic reset;

  spi_command_sequencer_if bus ();

  spi_command_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks    = 0;
  int failures  = 0;
  int ovf_cnt   = 0;
  int bad_cnt   = 0;
  int stall_err = 0;

  entry_t      obs_pop [$];
  logic [24:0] obs_wr  [$];
  logic        prev_stall = 1'b0;
  entry_t      prev_head;

  // Reference model state for the randomized phase.
  entry_t      mq      [$];
  entry_t      exp_pop [$];
  logic [24:0] exp_wr  [$];
  int          exp_ovf;
  int          exp_bad;
  int          ready_pct;

  function automatic entry_t head();
    return {bus.draw_id, bus.draw_x, bus.draw_y, bus.draw_flags};
  endfunction

  function automatic entry_t mk(input int k);
    return {8'(k), 16'(k * 100), 16'(k * 7 + 1), 8'(k) ^ 8'h30};
  endfunction

  // Passive monitor, sampling mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.sprite_we) obs_wr.push_back({bus.sprite_id, bus.sprite_addr, bus.sprite_wdata});
      if (bus.overflow) ovf_cnt++;
      if (bus.bad_cmd) bad_cnt++;
      if (bus.draw_valid && bus.draw_ready) obs_pop.push_back(head());
      if (prev_stall && (!bus.draw_valid || head() !== prev_head)) stall_err++;
      prev_stall = bus.draw_valid && !bus.draw_ready;
      prev_head  = head();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time=%0t limit=400000", $time);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_draw(input entry_t e);
    send(8'h02);
    send(e.id);
    send(e.x[15:8]);
    send(e.x[7:0]);
    send(e.y[15:8]);
    send(e.y[7:0]);
    send(e.flags);
  endtask

  // One cycle of the randomized phase; the queue model advances on the edge.
  task automatic rsend(input logic v, input logic [7:0] b, input logic c,
                       input bit push, input entry_t e);
    int occ;
    int pop;
    bus.byte_valid = v;
    bus.byte_data  = b;
    bus.cs         = c;
    bus.draw_ready = ($urandom_range(0, 99) < ready_pct);
    @(posedge clock);
    occ = mq.size();
    pop = (occ > 0 && bus.draw_ready) ? 1 : 0;
    if (pop == 1) exp_pop.push_back(mq.pop_front());
    if (push) begin
      if (occ - pop < FIFO_DEPTH) mq.push_back(e);
      else exp_ovf++;
    end
    #1;
    bus.byte_valid = 1'b0;
    bus.cs         = 1'b0;
  endtask

  task automatic r_byte(input logic [7:0] b, input bit push, input entry_t e);
    if ($urandom_range(0, 4) == 0) rsend(1'b0, 8'($urandom), 1'b0, 1'b0, '0);
    rsend(1'b1, b, 1'b0, push, e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cs         = 1'($urandom_range(0, 1));
      bus.byte_valid = 1'($urandom_range(0, 1));
      bus.byte_data  = 8'($urandom);
      bus.draw_ready = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("reset_sprite_status_%0d", i),
            {bus.sprite_we, bus.sprite_id, bus.sprite_addr, bus.sprite_wdata,
             bus.busy, bus.overflow, bus.bad_cmd}, '0);
      check($sformatf("reset_draw_%0d", i), {bus.draw_valid, head()}, '0);
    end
    bus.cs = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = '0; bus.draw_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_save();
    int errs;
    int b0;
    obs_wr.delete();
    b0 = bad_cnt;
    send(8'h01);
    check("save_busy_after_opcode", bus.busy, 1'b1);
    send(8'h07);
    for (int i = 0; i < 512; i++) begin
      if (i % 97 == 50) tick();
      send(8'(i));
    end
    check("save_busy_after_last", bus.busy, 1'b0);
    check("save_last_we", bus.sprite_we, 1'b1);
    tick();
    check("save_we_single_cycle", bus.sprite_we, 1'b0);
    check("save_write_count", obs_wr.size(), 512);
    errs = 0;
    for (int i = 0; i < 512 && i < obs_wr.size(); i++)
      if (obs_wr[i] !== {8'h07, 9'(i), 8'(i)}) errs++;
    check("save_write_data", errs, 0);
    send(8'h02);
    check("save_then_cmd_busy", bus.busy, 1'b1);
    check("save_then_cmd_no_bad", bad_cnt - b0, 0);
    bus.cs = 1'b1;
    tick();
    bus.cs = 1'b0;
    check("save_then_cmd_abort_busy", bus.busy, 1'b0);
  endtask

  task automatic test_draw_table();
    draw_vec_t dv [5];
    dv[0] = '{56'h02_03_01_2C_00_C8_05, 8'h03, 16'd300,    16'd200,    8'h05};
    dv[1] = '{56'h02_FF_FF_FF_FF_FF_FF, 8'hFF, 16'd65535,  16'd65535,  8'hFF};
    dv[2] = '{56'h02_00_00_00_00_00_00, 8'h00, 16'd0,      16'd0,      8'h00};
    dv[3] = '{56'h02_A5_12_34_56_78_9C, 8'hA5, 16'h1234,   16'h5678,   8'h9C};
    dv[4] = '{56'h02_01_00_FF_FF_00_80, 8'h01, 16'd255,    16'd65280,  8'h80};
    bus.draw_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 7; k++) send(dv[v].bytes[8*(6-k) +: 8]);
      check($sformatf("draw_vec%0d_valid", v), bus.draw_valid, 1'b1);
      check($sformatf("draw_vec%0d_entry", v), head(),
            {dv[v].id, dv[v].x, dv[v].y, dv[v].flags});
      tick();
      check($sformatf("draw_vec%0d_popped", v), bus.draw_valid, 1'b0);
    end
    bus.draw_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int errs;
    int ovf0;
    entry_t e;
    ovf0 = ovf_cnt;
    bus.draw_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_draw(mk(k));
    check("bp_no_ovf_first4", ovf_cnt - ovf0, 0);
    send_draw(mk(5));
    check("bp_ovf_on_id5", bus.overflow, 1'b1);
    tick();
    check("bp_ovf_single_pulse", bus.overflow, 1'b0);
    check("bp_ovf_count", ovf_cnt - ovf0, 1);
    tick();
    check("bp_head_stalled", head(), mk(1));
    obs_pop.delete();
    for (int i = 0; i < 16; i++) begin
      bus.draw_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.draw_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("bp_pop_count", obs_pop.size(), 4);
    errs = 0;
    for (int i = 0; i < obs_pop.size() && i < 4; i++) if (obs_pop[i] !== mk(i + 1)) errs++;
    check("bp_pop_order", errs, 0);
    check("bp_drained", bus.draw_valid, 1'b0);

    // Full queue with a pop in the same cycle as the push: accepted.
    bus.draw_ready = 1'b0;
    for (int k = 11; k <= 14; k++) send_draw(mk(k));
    obs_pop.delete();
    ovf0 = ovf_cnt;
    e = mk(15);
    send(8'h02); send(e.id); send(e.x[15:8]); send(e.x[7:0]); send(e.y[15:8]); send(e.y[7:0]);
    bus.draw_ready = 1'b1;
    send(e.flags);
    check("full_push_pop_no_ovf", bus.overflow, 1'b0);
    check("full_push_pop_head", bus.draw_id, 8'd12);
    for (int i = 0; i < 6; i++) tick();
    check("full_push_pop_count", obs_pop.size(), 5);
    errs = 0;
    for (int i = 0; i < obs_pop.size() && i < 5; i++) if (obs_pop[i] !== mk(11 + i)) errs++;
    check("full_push_pop_order", errs, 0);
    check("full_push_pop_no_ovf_total", ovf_cnt - ovf0, 0);
    bus.draw_ready = 1'b0;
  endtask

  task automatic test_abort();
    int errs;
    int b0;
    entry_t e;
    obs_wr.delete();
    bus.draw_ready = 1'b0;
    send(8'h01);
    send(8'h09);
    for (int i = 0; i < 100; i++) send(8'(i) ^ 8'h5A);
    bus.cs = 1'b1;
    send(8'hEE);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_no_we_on_cs", bus.sprite_we, 1'b0);
    b0 = bad_cnt;
    send(8'hFF);
    check("cs_high_byte_ignored", bus.bad_cmd, 1'b0);
    bus.cs = 1'b0;
    tick();
    check("abort_write_count", obs_wr.size(), 100);
    errs = 0;
    for (int i = 0; i < 100 && i < obs_wr.size(); i++)
      if (obs_wr[i] !== {8'h09, 9'(i), 8'(i) ^ 8'h5A}) errs++;
    check("abort_write_data", errs, 0);
    check("cs_high_no_bad_count", bad_cnt - b0, 0);

    send(8'h02); send(8'h44); send(8'h01); send(8'h02);
    bus.cs = 1'b1;
    tick();
    bus.cs = 1'b0;
    tick();
    check("abort_draw_busy", bus.busy, 1'b0);
    check("abort_draw_no_push", bus.draw_valid, 1'b0);
    e = '{id: 8'h21, x: 16'h0102, y: 16'h0304, flags: 8'h7E};
    send_draw(e);
    check("after_abort_draw_valid", bus.draw_valid, 1'b1);
    check("after_abort_draw_entry", head(), e);
    bus.draw_ready = 1'b1;
    tick();
    check("after_abort_draw_popped", bus.draw_valid, 1'b0);
    bus.draw_ready = 1'b0;
  endtask

  task automatic test_opcodes();
    op_vec_t ov [4];
    entry_t e;
    ov[0] = '{8'hFF, 1'b1};
    ov[1] = '{8'h00, 1'b1};
    ov[2] = '{8'h03, 1'b1};
    ov[3] = '{8'h80, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(ov[i].op);
      check($sformatf("op_%0h_bad", ov[i].op), bus.bad_cmd, ov[i].exp_bad);
      check($sformatf("op_%0h_busy", ov[i].op), bus.busy, 1'b0);
      tick();
      check($sformatf("op_%0h_bad_pulse", ov[i].op), bus.bad_cmd, 1'b0);
    end
    e = '{id: 8'h5C, x: 16'd1000, y: 16'd42, flags: 8'h11};
    bus.draw_ready = 1'b1;
    send_draw(e);
    check("op_then_draw_entry", {bus.draw_valid, head()}, {1'b1, e});
    tick();
    bus.draw_ready = 1'b0;
  endtask

  task automatic test_random();
    int errs, ovf0, bad0, kind, n_arg, n_pix;
    entry_t e;
    logic [7:0] id, d;
    check("rand_start_empty", bus.draw_valid, 1'b0);
    obs_pop.delete(); obs_wr.delete(); mq.delete(); exp_pop.delete(); exp_wr.delete();
    exp_ovf = 0; exp_bad = 0;
    ovf0 = ovf_cnt; bad0 = bad_cnt;
    for (int n = 0; n < 200; n++) begin
      ready_pct = (n < 100) ? 20 : 80;
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          d = 8'($urandom_range(3, 255));
          if ($urandom_range(0, 3) == 0) d = 8'h00;
          r_byte(d, 1'b0, '0);
          exp_bad++;
        end
        1: begin
          e.id = 8'($urandom); e.x = 16'($urandom); e.y = 16'($urandom); e.flags = 8'($urandom);
          r_byte(8'h02, 1'b0, '0);
          r_byte(e.id, 1'b0, '0);
          r_byte(e.x[15:8], 1'b0, '0);
          r_byte(e.x[7:0], 1'b0, '0);
          r_byte(e.y[15:8], 1'b0, '0);
          r_byte(e.y[7:0], 1'b0, '0);
          r_byte(e.flags, 1'b1, e);
        end
        2: begin
          n_arg = $urandom_range(0, 5);
          r_byte(8'h02, 1'b0, '0);
          for (int j = 0; j < n_arg; j++) r_byte(8'($urandom), 1'b0, '0);
          rsend(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b0, '0);
        end
        3: begin
          id = 8'($urandom);
          n_pix = $urandom_range(0, 12);
          r_byte(8'h01, 1'b0, '0);
          r_byte(id, 1'b0, '0);
          for (int j = 0; j < n_pix; j++) begin
            d = 8'($urandom);
            exp_wr.push_back({id, 9'(j), d});
            r_byte(d, 1'b0, '0);
          end
          rsend(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b0, '0);
        end
        default: rsend(1'b1, 8'($urandom), 1'b1, 1'b0, '0);
      endcase
    end
    ready_pct = 100;
    for (int i = 0; i < 20 && mq.size() > 0; i++) rsend(1'b0, 8'h00, 1'b0, 1'b0, '0);
    check("rand_drain_bound", mq.size(), 0);
    bus.draw_ready = 1'b0;
    tick();
    check("rand_pop_count", obs_pop.size(), exp_pop.size());
    errs = 0;
    for (int i = 0; i < obs_pop.size() && i < exp_pop.size(); i++)
      if (obs_pop[i] !== exp_pop[i]) errs++;
    check("rand_pop_data", errs, 0);
    check("rand_write_count", obs_wr.size(), exp_wr.size());
    errs = 0;
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      if (obs_wr[i] !== exp_wr[i]) errs++;
    check("rand_write_data", errs, 0);
    check("rand_overflow_count", ovf_cnt - ovf0, exp_ovf);
    check("rand_bad_cmd_count", bad_cnt - bad0, exp_bad);
    check("rand_end_idle", bus.busy, 1'b0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.cs         = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.draw_ready = 1'b0;
    ready_pct      = 50;
    test_reset();
    test_save();
    test_draw_table();
    test_backpressure();
    test_abort();
    test_opcodes();
    test_random();
    check("draw_stable_while_stalled", stall_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
